// File: rtl/parking_pkg.sv
// parking_pkg: shared gate FSM state type and default timing constants for the parking front end
package parking_pkg;
  typedef enum logic [2:0] {IDLE, DEB, DECIDE, CHECK, OPEN, DENY} gate_state_t;
  localparam int COUNT_W = 9;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_OPEN_CYCLES = 16;
endpackage

// File: rtl/parking_debounce.sv
// parking_debounce: counts consecutive high loop samples; done flags that the next sample completes the debounce
//   clk, reset : clock, async active-high reset
//   start      : load the counter with 1 (first high sample)
//   step       : increment on a further high sample; counter clears when neither start nor step
//   done       : counter already holds CYCLES-1
module parking_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic step,
  output logic done
);
  localparam int W = $clog2(CYCLES + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= start ? W'(1) : step ? cnt + 1'b1 : '0;
  assign done = cnt == W'(CYCLES - 1);
endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: entry/exit gate front end issuing admission pulses to Parking and driving the barriers
//   clk, reset                         : clock, async active-high reset
//   entry_detect/exit_detect           : raw loop sensor levels
//   entry_uni_tag/exit_uni_tag         : university permit tags, latched when debounce completes
//   uni_is_vacated_space, is_vacated_space, illegal_enter, illegal_exit : status from Parking
//   car_entered/car_exited (+is_uni_*) : one-cycle requests to Parking
//   *_barrier_open, *_denied, *_fault  : barrier, refusal and sticky open-timeout outputs
//   PARKING_GATE_SERIALIZE_EN          : when defined, entry and exit pulses never coincide (exit wins)
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int OPEN_CYCLES = DEF_OPEN_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic entry_detect,
  input  logic entry_uni_tag,
  input  logic exit_detect,
  input  logic exit_uni_tag,
  input  logic uni_is_vacated_space,
  input  logic is_vacated_space,
  input  logic illegal_enter,
  input  logic illegal_exit,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited,
  output logic entry_barrier_open,
  output logic exit_barrier_open,
  output logic entry_denied,
  output logic exit_denied,
  output logic entry_fault,
  output logic exit_fault
);
`ifdef PARKING_GATE_SERIALIZE_EN
  localparam bit SERIALIZE = 1'b1;
`else
  localparam bit SERIALIZE = 1'b0;
`endif
  localparam int OW = $clog2(OPEN_CYCLES + 1);
  logic [1:0] det, tag_in, ill, in_decide, pulse, uni, barrier, deny, fault;
  assign det = {exit_detect, entry_detect};
  assign tag_in = {exit_uni_tag, entry_uni_tag};
  assign ill = {illegal_exit, illegal_enter};
  // index 0 = entry gate, index 1 = exit gate
  for (genvar g = 0; g < 2; g++) begin : gate
    gate_state_t st, st_nxt;
    logic tag_r, vac_r, fault_r, done, hold, vac_now, deb_end;
    logic [OW-1:0] tcnt;
    // entry yields DECIDE to a simultaneous exit decision when serialized
    assign hold = (g == 0) && SERIALIZE && in_decide[1];
    assign deb_end = st == DEB && det[g] && done;
    // vacancy is registered with the tag so the pulse stays a pure state decode; exit never needs a space
    assign vac_now = (g == 1) || ((deb_end ? tag_in[g] : tag_r) ? uni_is_vacated_space : is_vacated_space);
    parking_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk(clk),
      .reset(reset),
      .start(st == IDLE && det[g]),
      .step(st == DEB && det[g]),
      .done(done)
    );
    always_comb begin
      st_nxt = st;
      case (st)
        IDLE: st_nxt = det[g] ? DEB : IDLE;
        DEB: st_nxt = !det[g] ? IDLE : done ? DECIDE : DEB;
        DECIDE: st_nxt = hold ? DECIDE : vac_r ? CHECK : DENY;
        CHECK: st_nxt = ill[g] ? DENY : OPEN;
        OPEN, DENY: st_nxt = det[g] ? st : IDLE;
        default: st_nxt = IDLE;
      endcase
    end
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        st <= IDLE;
        tag_r <= 1'b0;
        vac_r <= 1'b0;
        tcnt <= '0;
        fault_r <= 1'b0;
      end else begin
        st <= st_nxt;
        if (deb_end) tag_r <= tag_in[g];
        if (deb_end || (st == DECIDE && hold)) vac_r <= vac_now;
        tcnt <= (st == OPEN && det[g]) ? ((tcnt == OW'(OPEN_CYCLES)) ? tcnt : tcnt + 1'b1) : '0;
        if (st == OPEN && det[g] && tcnt == OW'(OPEN_CYCLES - 1)) fault_r <= 1'b1;
      end
    assign in_decide[g] = st == DECIDE;
    assign pulse[g] = st == DECIDE && vac_r && !hold;
    assign uni[g] = pulse[g] && tag_r;
    assign barrier[g] = st == OPEN;
    assign deny[g] = st == DENY;
    assign fault[g] = fault_r;
  end
  assign car_entered = pulse[0];
  assign is_uni_car_entered = uni[0];
  assign car_exited = pulse[1];
  assign is_uni_car_exited = uni[1];
  assign entry_barrier_open = barrier[0];
  assign exit_barrier_open = barrier[1];
  assign entry_denied = deny[0];
  assign exit_denied = deny[1];
  assign entry_fault = fault[0];
  assign exit_fault = fault[1];
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: directed and randomized vehicle sequences checked against a timeline model of the gate rules
module tb_parking_gate_ctrl;
  localparam int D = 4;
  localparam int O = 16;
`ifdef PARKING_GATE_SERIALIZE_EN
  localparam int S = 1;
`else
  localparam int S = 0;
`endif
  logic clk = 1'b0;
  logic reset, entry_detect, entry_uni_tag, exit_detect, exit_uni_tag;
  logic uni_is_vacated_space, is_vacated_space, illegal_enter, illegal_exit;
  logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic entry_barrier_open, exit_barrier_open, entry_denied, exit_denied, entry_fault, exit_fault;
  logic [9:0] obs;
  logic [1:0] fault_m;
  int checks = 0;
  int errors = 0;
  parking_gate_ctrl dut (
    .clk(clk), .reset(reset),
    .entry_detect(entry_detect), .entry_uni_tag(entry_uni_tag),
    .exit_detect(exit_detect), .exit_uni_tag(exit_uni_tag),
    .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
    .illegal_enter(illegal_enter), .illegal_exit(illegal_exit),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
    .entry_barrier_open(entry_barrier_open), .exit_barrier_open(exit_barrier_open),
    .entry_denied(entry_denied), .exit_denied(exit_denied),
    .entry_fault(entry_fault), .exit_fault(exit_fault)
  );
  always #5 clk = ~clk;
  // per gate: {fault, denied, barrier, is_uni, pulse}
  assign obs = {exit_fault, exit_denied, exit_barrier_open, is_uni_car_exited, car_exited,
                entry_fault, entry_denied, entry_barrier_open, is_uni_car_entered, car_entered};
  task automatic check(string tag, logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  // Expected {denied, barrier, is_uni, pulse} after edge k for a vehicle whose loop is high on edges 1..L.
  function automatic logic [3:0] gate_exp(int k, int L, bit tag, bit ok, bit ill);
    int e = (L > D + 2) ? L : D + 2;
    int de = (L > D + 1) ? L : D + 1;
    bit go = L >= D;
    bit p = go && ok && k == D;
    bit b = go && ok && !ill && k >= D + 2 && k <= e;
    bit dn = go && ((!ok && k >= D + 1 && k <= de) || (ok && ill && k >= D + 2 && k <= e));
    return {dn, b, p && tag, p};
  endfunction
  task automatic run_vehicle(string name, int g, int L, bit tag, bit vac, bit ill);
    int total = (L >= D) ? (((L > D + 2) ? L : D + 2) + 2) : L + 2;
    bit ok = (g == 1) || vac;
    logic [3:0] e;
    if (g == 0) begin
      entry_uni_tag = tag;
      uni_is_vacated_space = tag ? vac : !vac;
      is_vacated_space = tag ? !vac : vac;
      illegal_enter = ill;
    end else begin
      exit_uni_tag = tag;
      illegal_exit = ill;
    end
    for (int k = 1; k <= total; k++) begin
      if (g == 0) entry_detect = (k <= L);
      else exit_detect = (k <= L);
      @(posedge clk);
      #1;
      if (k == D) begin
        if (g == 0) entry_uni_tag = 1'($urandom);
        else exit_uni_tag = 1'($urandom);
      end
      if (ok && !ill && L >= D + 2 + O && k >= D + 2 + O) fault_m[g] = 1'b1;
      e = gate_exp(k, L, tag, ok, ill);
      check(name, g == 0 ? {fault_m[1], 4'b0, fault_m[0], e} : {fault_m[1], e, fault_m[0], 4'b0});
    end
  endtask
  initial begin
    reset = 1'b1;
    {entry_detect, entry_uni_tag, exit_detect, exit_uni_tag} = '0;
    {uni_is_vacated_space, is_vacated_space, illegal_enter, illegal_exit} = '0;
    fault_m = '0;
    #2;
    check("reset_state", 10'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    run_vehicle("short_glitch", 0, 3, 1'b1, 1'b1, 1'b0);
    run_vehicle("uni_admit", 0, 8, 1'b1, 1'b1, 1'b0);
    run_vehicle("no_vacancy", 0, 7, 1'b0, 1'b0, 1'b0);
    run_vehicle("exit_illegal", 1, 7, 1'b0, 1'b1, 1'b1);
    run_vehicle("exit_ok_uni", 1, 9, 1'b1, 1'b1, 1'b0);
    entry_uni_tag = 1'b1;
    exit_uni_tag = 1'b0;
    uni_is_vacated_space = 1'b1;
    is_vacated_space = 1'b1;
    illegal_enter = 1'b0;
    illegal_exit = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      entry_detect = (k <= 10);
      exit_detect = (k <= 10);
      @(posedge clk);
      #1;
      check("both_gates", {fault_m[1], gate_exp(k, 10, 1'b0, 1'b1, 1'b0),
                           fault_m[0], gate_exp(k - S, 10 - S, 1'b1, 1'b1, 1'b0)});
    end
    for (int v = 0; v < 40; v++)
      run_vehicle("random", int'($urandom_range(0, 1)), int'($urandom_range(1, 26)),
                  1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    reset = 1'b1;
    fault_m = '0;
    #1;
    check("reset_clears", 10'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    entry_uni_tag = 1'b0;
    is_vacated_space = 1'b1;
    uni_is_vacated_space = 1'b0;
    illegal_enter = 1'b0;
    entry_detect = 1'b1;
    for (int k = 1; k <= D + 2 + O; k++) begin
      @(posedge clk);
      #1;
      if (k == D + 1 + O) check("fault_not_yet", {5'b0, 5'b00100});
    end
    check("fault_set_open", {5'b0, 5'b10100});
    @(posedge clk);
    #1;
    check("fault_sticky", {5'b0, 5'b10100});
    reset = 1'b1;
    #1;
    check("reset_mid_open", 10'b0);
    entry_detect = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_reset", 10'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
Gate-side front end that sits directly upstream of the Parking occupancy counter.
- Debounces the raw entry and exit loop-detector levels and latches the university-permit tag.
- Asks Parking for admission by issuing the one-cycle car_entered / car_exited pulses (with is_uni qualifiers).
- Reads back the vacancy and illegal flags from Parking and drives the entry and exit barriers.
- Entry and exit each run an independent Moore FSM.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive high samples of detect needed to accept a vehicle.
- OPEN_CYCLES, 16: cycles a barrier may stay open with detect still high before a fault is flagged.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; start-of-day reset shared with Parking.
- entry_detect  input  1  raw entry loop sensor level.
- entry_uni_tag  input  1  1 = vehicle at entry carries a university permit.
- exit_detect  input  1  raw exit loop sensor level.
- exit_uni_tag  input  1  1 = vehicle at exit carries a university permit.
- uni_is_vacated_space  input  1  from Parking: a university space is free.
- is_vacated_space  input  1  from Parking: a free (public) space is free.
- illegal_enter  input  1  from Parking: last entry request was rejected.
- illegal_exit  input  1  from Parking: last exit request was rejected.
- car_entered  output  1  one-cycle entry request pulse to Parking.
- is_uni_car_entered  output  1  qualifier, valid only while car_entered = 1, else 0.
- car_exited  output  1  one-cycle exit request pulse to Parking.
- is_uni_car_exited  output  1  qualifier, valid only while car_exited = 1, else 0.
- entry_barrier_open  output  1  1 = entry barrier raised.
- exit_barrier_open  output  1  1 = exit barrier raised.
- entry_denied  output  1  entry refused; held until the vehicle leaves the loop.
- exit_denied  output  1  exit refused; held until the vehicle leaves the loop.
- entry_fault  output  1  sticky open-timeout flag, entry side.
- exit_fault  output  1  sticky open-timeout flag, exit side.

Behaviour:
Reset and output timing
- Reset asserted, including mid-operation: both FSMs go to IDLE, all counters clear, every output = 0, faults clear.
- All outputs are decoded from state registers only (Moore); no input-to-output combinational path.

Entry FSM: IDLE, DEB, DECIDE, CHECK, OPEN, DENY
- IDLE: entry_detect = 1 on an edge -> DEB with cnt = 1.
- DEB: detect = 0 -> IDLE. Otherwise cnt increments; the edge on which cnt reaches DEBOUNCE_CYCLES -> DECIDE, and entry_uni_tag is latched on that same edge.
- DECIDE (1 cycle), vacancy flag selected by the latched tag (uni -> uni_is_vacated_space, else is_vacated_space):
  - flag = 1: car_entered = 1 and is_uni_car_entered = tag during this cycle; -> CHECK.
  - flag = 0: -> DENY with no pulse.
- CHECK (1 cycle): samples illegal_enter. 1 -> DENY, 0 -> OPEN.
- OPEN: entry_barrier_open = 1.
  - detect = 0 on an edge -> IDLE; the barrier drops on that edge.
  - OPEN_CYCLES edges spent in OPEN with detect still 1: entry_fault sets (sticky); the barrier stays open.
- DENY: entry_denied = 1; detect = 0 -> IDLE.

Entry latency (D = DEBOUNCE_CYCLES)
- Pulse occupies the cycle after edge D.
- Barrier rises at edge D+2; denial rises at edge D+1 (no vacancy) or D+2 (illegal).

Exit FSM: identical states and timing, with two differences
- DECIDE always pulses car_exited, with is_uni_car_exited = latched exit_uni_tag.
- CHECK samples illegal_exit.

Concurrency and counters
- The two FSMs run independently; entry and exit pulses may coincide in the same cycle.
- Debounce counter width: $clog2(DEBOUNCE_CYCLES+1).
- Timeout counter width: $clog2(OPEN_CYCLES+1); it saturates and never wraps.
- A vehicle glitch during DEB restarts debounce from IDLE.

Optional Feature:
PARKING_GATE_SERIALIZE_EN
- Defined:
  - car_entered and car_exited are never high in the same cycle.
  - If both FSMs would be in DECIDE together, exit has priority.
  - Entry holds in DECIDE one extra cycle and re-evaluates vacancy then.
- Undefined: no arbitration; pulses may coincide.

Decomposition:
- parking_pkg holds:
  - entry/exit state enum typedef;
  - COUNT_W = 9;
  - default DEBOUNCE_CYCLES / OPEN_CYCLES localparams.
- Sub-module parking_debounce (counter plus a done flag) is instantiated once per gate.

Test Plan:
1. Reset; then entry_detect high 3 edges then low -> no car_entered, entry_barrier_open stays 0, FSM back in IDLE.
2. entry_detect = 1, entry_uni_tag = 1, uni_is_vacated_space = 1, illegal_enter = 0 -> car_entered = is_uni_car_entered = 1 for 1 cycle after edge 4; barrier = 1 from edge 6; barrier drops on the first edge with detect = 0.
3. entry_detect = 1, tag = 0, is_vacated_space = 0 -> no pulse; entry_denied = 1 from edge 5 until detect falls.
4. exit_detect = 1, tag = 0, illegal_exit = 1 during CHECK -> car_exited pulse after edge 4; exit_denied = 1 from edge 6; exit_barrier_open stays 0.
5. Both detects rise on the same edge with vacancy available:
   - macro undefined -> both pulses after edge 4;
   - macro defined -> car_exited after edge 4, car_entered after edge 5.
6. Entry reaches OPEN, detect held high 16 more edges -> entry_fault = 1, barrier still open; then reset asserted -> all outputs 0 immediately.
